m_coherent_acc: RTL and testbench
=================================

# m_coherent_acc

- Coherent integration stage directly downstream of the 4x4 unsigned multipliers in the correlation datapath.
- Takes one sign-magnitude product per valid cycle (8-bit magnitude plus sign) and accumulates it as a signed value over a programmable number of samples.
- Presents each completed sum to the correlator result logic through a valid/ready holding register.

## Interface
Parameters:
- ACC_WIDTH, 20, signed accumulator and dump width (min 9)
- LEN_WIDTH, 10, width of the dump length field

Ports:
- clk  input  1  system clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- clear_i  input  1  synchronous restart; discards accumulation and pending dump
- dump_length_i  input  LEN_WIDTH  samples per dump; 0 treated as 1
- sample_valid_i  input  1  product_i/sign_i valid this cycle
- sign_i  input  1  1 = product negative
- product_i  input  8  unsigned product magnitude, 0..225
- dump_valid_o  output  1  holding register contains a result
- dump_ready_i  input  1  consumer accepts result when dump_valid_o high
- dump_value_o  output  ACC_WIDTH  signed two's-complement completed sum
- dump_overflow_o  output  1  saturation occurred in the period of dump_value_o
- dump_overrun_o  output  1  one-cycle pulse: unread dump overwritten

## Operation
- Signed term is +product_i when sign_i=0, −product_i when sign_i=1. It is sign-extended to ACC_WIDTH+1 bits before the add.
- Length latch:
  - When sample count is 0 and sample_valid_i=1, the length register loads max(dump_length_i,1).
  - dump_length_i changes during a period take effect next period.
- Accumulate: each valid sample adds its term to acc and increments cnt.
- Completion: the valid sample for which cnt+1 equals the latched length.
  - acc+term (plus its overflow flag) loads into the holding register.
  - acc and cnt return to 0 in the same edge, so there is no dead cycle; the next sample starts a new period.
- Holding register states:
  - EMPTY → FULL on completion.
  - FULL → EMPTY when dump_ready_i=1 and no completion occurs that cycle.
  - FULL + completion + dump_ready_i=1: new value loads, stays FULL, no overrun.
  - FULL + completion + dump_ready_i=0: new value overwrites, dump_overrun_o pulses for one cycle.
- Overflow flag:
  - Sticky within a period; set when an add saturates (see Configuration).
  - Cleared at period start and travels with the dump.
- clear_i has highest priority: acc, cnt and the overflow flag are zeroed and dump_valid_o drops next cycle. Any sample in the same cycle is discarded.
- sample_valid_i=0 cycles hold all state; a gap inside a period is allowed.

## Timing
- Reset values: dump_valid_o=0, dump_value_o=0, dump_overflow_o=0, dump_overrun_o=0. acc, cnt and the length register are also 0.
- Reset asserted mid-period drops the partial sum; no dump is produced.
- Latency: completing sample at edge t gives dump_valid_o=1 with the final value after edge t (visible in cycle t+1).
- Throughput: one sample per clock, sustained, including back-to-back periods with length 1.
- Handshake:
  - The transfer occurs on the edge where dump_valid_o and dump_ready_i are both high.
  - dump_value_o and dump_overflow_o stay stable while valid is high and unaccepted, except on an overwrite, which is flagged by dump_overrun_o.
- dump_ready_i has no combinational path to any output.

## Configuration
- ACC_SATURATE_EN defined:
  - Sums clamp to ±(2^(ACC_WIDTH−1)−1).
  - Any clamp sets the period's overflow flag.
- ACC_SATURATE_EN undefined:
  - Sums wrap modulo 2^ACC_WIDTH.
  - dump_overflow_o is constant 0 and the flag logic is removed.

## Test plan
- Basic sum: length 4; samples +225, +225, −10, +3 → one dump, value 443, overflow 0, valid one cycle after the 4th sample.
- Length 0 and back-to-back: length 0 with continuous samples +5, −7, +1 → three consecutive dumps 5, −7, 1, with dump_ready_i held 1.
- Overrun and simultaneity: length 1, dump_ready_i=0, samples +1, +2 → dump_value_o=2 and dump_overrun_o pulses once. Repeat with dump_ready_i=1 on the second completion → no overrun pulse.
- Saturation with ACC_SATURATE_EN and ACC_WIDTH=10: length 3, samples 3×+225 → value 511, overflow 1. Next period 1×−4 → value −4, overflow 0. Without the macro, the same stimulus → value 675−1024 = −349, overflow 0.
- Clear/reset mid-period: length 8; after 3 samples of +100 assert clear_i, then feed 8 samples of +1 → dump value 8. Repeat with rst_b pulsed low instead → same result, and all outputs read 0 during reset.
- Length change: length 2, then switch dump_length_i to 3 after the first sample → first dump uses 2 samples, the following dump uses 3.

Source files
------------

// File: rtl/m_coherent_acc_if.sv
// Sample-in / dump-out bundle of the coherent integrator.
// master = product source and result consumer, slave = the integrator.
interface m_coherent_acc_if #(
  parameter int ACC_WIDTH = 20,
  parameter int LEN_WIDTH = 10
);
  logic                        clear_i;
  logic [LEN_WIDTH-1:0]        dump_length_i;
  logic                        sample_valid_i;
  logic                        sign_i;
  logic [7:0]                  product_i;

  // Dump handshake: a result transfers on every rising edge where dump_valid_o
  // and dump_ready_i are both high. While valid is high and not yet accepted,
  // value and overflow hold, unless a newer dump overwrites them
  // (signalled by the one-cycle dump_overrun_o pulse). Ready never
  // reaches an output combinationally.
  logic                        dump_valid_o;
  logic                        dump_ready_i;
  logic signed [ACC_WIDTH-1:0] dump_value_o;
  logic                        dump_overflow_o;
  logic                        dump_overrun_o;

  modport master (
    output clear_i, dump_length_i, sample_valid_i, sign_i, product_i, dump_ready_i,
    input  dump_valid_o, dump_value_o, dump_overflow_o, dump_overrun_o
  );

  modport slave (
    input  clear_i, dump_length_i, sample_valid_i, sign_i, product_i, dump_ready_i,
    output dump_valid_o, dump_value_o, dump_overflow_o, dump_overrun_o
  );
endinterface

// File: rtl/m_coherent_acc.sv
// Coherent integrator: accumulates signed products over a programmable length into a one-deep dump register.
// Define ACC_SATURATE_EN to clamp sums and report overflow; otherwise sums wrap and overflow reads 0.
module m_coherent_acc #(
  parameter int ACC_WIDTH = 20,
  parameter int LEN_WIDTH = 10
) (
  input  logic            clk,
  input  logic            rst_b,
  m_coherent_acc_if.slave bus,
  output logic            dbg_hold_full
);

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

`ifdef ACC_SATURATE_EN
  localparam int SUM_W = ACC_WIDTH + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {2'b11, {(ACC_WIDTH-2){1'b0}}, 1'b1};
`else
  // Without clamping the guard bit carries no information; modulo arithmetic is exact at ACC_WIDTH.
  localparam int SUM_W = ACC_WIDTH;
`endif

  logic signed [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0]        cnt;
  logic [LEN_WIDTH-1:0]        len_q;
  logic [LEN_WIDTH-1:0]        len_eff;
  logic [LEN_WIDTH:0]          cnt_inc;
  logic                        period_start;
  logic                        done;

  logic signed [SUM_W-1:0]     mag;
  logic signed [SUM_W-1:0]     term;
  logic signed [SUM_W-1:0]     acc_ext;
  logic signed [SUM_W-1:0]     sum;
  logic signed [ACC_WIDTH-1:0] sum_fit;

  hold_state_t                 hold_state;
  logic signed [ACC_WIDTH-1:0] value_q;
  logic                        overrun_q;

`ifdef ACC_SATURATE_EN
  logic sat_hit;
  logic ovf_q;
  logic ovf_next;
  logic dump_ovf_q;
`endif

  // A fresh period uses the live length input; later samples use the value latched at its start.
  assign period_start = (cnt == '0);
  assign len_eff      = period_start
                        ? ((bus.dump_length_i == '0) ? LEN_WIDTH'(1) : bus.dump_length_i)
                        : len_q;
  assign cnt_inc      = {1'b0, cnt} + (LEN_WIDTH+1)'(1);
  assign done         = bus.sample_valid_i && (cnt_inc == {1'b0, len_eff});

  assign mag     = SUM_W'(bus.product_i);
  assign term    = bus.sign_i ? -mag : mag;
  assign acc_ext = SUM_W'(acc);
  assign sum     = acc_ext + term;

`ifdef ACC_SATURATE_EN
  always_comb begin
    sat_hit = 1'b0;
    sum_fit = sum[ACC_WIDTH-1:0];
    if (sum > SAT_MAX) begin
      sat_hit = 1'b1;
      sum_fit = SAT_MAX[ACC_WIDTH-1:0];
    end else if (sum < SAT_MIN) begin
      sat_hit = 1'b1;
      sum_fit = SAT_MIN[ACC_WIDTH-1:0];
    end
  end

  // Sticky within a period; the first sample of a period starts from a clean flag.
  assign ovf_next = (!period_start && ovf_q) || sat_hit;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ovf_q <= 1'b0;
    end else if (bus.clear_i) begin
      ovf_q <= 1'b0;
    end else if (bus.sample_valid_i) begin
      ovf_q <= done ? 1'b0 : ovf_next;
    end
  end
`else
  assign sum_fit = sum;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (bus.clear_i) begin
      acc <= '0;
      cnt <= '0;
    end else if (bus.sample_valid_i) begin
      if (period_start) begin
        len_q <= len_eff;
      end
      if (done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum_fit;
        cnt <= cnt_inc[LEN_WIDTH-1:0];
      end
    end
  end

  // Holding register: a completion always wins the slot; dropping an unread dump raises overrun.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hold_state <= HOLD_EMPTY;
      value_q    <= '0;
      overrun_q  <= 1'b0;
`ifdef ACC_SATURATE_EN
      dump_ovf_q <= 1'b0;
`endif
    end else begin
      overrun_q <= 1'b0;
      if (bus.clear_i) begin
        hold_state <= HOLD_EMPTY;
      end else if (done) begin
        hold_state <= HOLD_FULL;
        value_q    <= sum_fit;
        overrun_q  <= (hold_state == HOLD_FULL) && !bus.dump_ready_i;
`ifdef ACC_SATURATE_EN
        dump_ovf_q <= ovf_next;
`endif
      end else if ((hold_state == HOLD_FULL) && bus.dump_ready_i) begin
        hold_state <= HOLD_EMPTY;
      end
    end
  end

  assign bus.dump_valid_o   = (hold_state == HOLD_FULL);
  assign bus.dump_value_o   = value_q;
  assign bus.dump_overrun_o = overrun_q;
`ifdef ACC_SATURATE_EN
  assign bus.dump_overflow_o = dump_ovf_q;
`else
  assign bus.dump_overflow_o = 1'b0;
`endif
  assign dbg_hold_full = (hold_state == HOLD_FULL);

endmodule

// File: tb/tb_m_coherent_acc.sv
// Bench for m_coherent_acc: directed test-plan cases plus random traffic against a period-level reference model.
// Works with or without ACC_SATURATE_EN defined.
module tb_m_coherent_acc;
  localparam int W    = 10;
  localparam int L    = 10;
  localparam int MAXV = (1 << (W - 1)) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic dbg_hold_full;
  always #5 clk = ~clk;

  m_coherent_acc_if #(.ACC_WIDTH(W), .LEN_WIDTH(L)) bus ();

  m_coherent_acc #(.ACC_WIDTH(W), .LEN_WIDTH(L)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .bus           (bus),
    .dbg_hold_full (dbg_hold_full)
  );

  // ---------------- reference model state ----------------
  int   m_sum, m_cnt, m_len;
  bit   m_ovf, m_full;
  bit   nxt_full, nxt_ovr, vis_full, vis_ovr;
  logic [W:0] exp_q[$];
  logic [W:0] e;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Expected flags become visible after the edge they describe.
  always @(posedge clk) begin
    vis_full = nxt_full;
    vis_ovr  = nxt_ovr;
  end

  // ---------------- driver tasks ----------------
  task automatic model_zero();
    m_sum = 0; m_cnt = 0; m_len = 0; m_ovf = 0; m_full = 0;
    nxt_full = 0; nxt_ovr = 0;
    exp_q.delete();
  endtask

  task automatic step(input bit v, input bit s, input int p, input int len, input bit rdy_in, input bit clr);
    int raw;
    bit was_full;
    bit rdy;
    logic signed [W-1:0] wrapped;
    @(posedge clk); #1;
    rdy = clr ? 1'b0 : rdy_in;
    bus.sample_valid_i = v;
    bus.sign_i         = s;
    bus.product_i      = 8'(p);
    bus.dump_length_i  = L'(len);
    bus.dump_ready_i   = rdy;
    bus.clear_i        = clr;
    was_full = m_full;
    nxt_ovr  = 0;
    if (clr) begin
      m_sum = 0; m_cnt = 0; m_ovf = 0; m_full = 0;
      exp_q.delete();
    end else begin
      if (m_full && rdy) m_full = 0;
      if (v) begin
        if (m_cnt == 0) begin
          m_len = (len == 0) ? 1 : len;
          m_sum = 0;
          m_ovf = 0;
        end
        raw = m_sum + (s ? -p : p);
`ifdef ACC_SATURATE_EN
        if (raw > MAXV) begin raw = MAXV; m_ovf = 1; end
        else if (raw < -MAXV) begin raw = -MAXV; m_ovf = 1; end
`else
        wrapped = raw[W-1:0];
        raw = wrapped;
`endif
        m_sum = raw;
        m_cnt++;
        if (m_cnt == m_len) begin
          if (was_full && !rdy) begin
            nxt_ovr = 1;
            void'(exp_q.pop_back());
          end
          exp_q.push_back({m_ovf, W'(m_sum)});
          m_full = 1;
          m_cnt  = 0;
        end
      end
    end
    nxt_full = m_full;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, rdy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    bus.sample_valid_i = 0; bus.clear_i = 0; bus.dump_ready_i = 0;
    bus.sign_i = 0; bus.product_i = 0; bus.dump_length_i = 0;
    rst_b = 0;
    model_zero();
    vis_full = 0; vis_ovr = 0;
    #1;
    chk("rst_valid",    bus.dump_valid_o,    0);
    chk("rst_value",    bus.dump_value_o,    0);
    chk("rst_overflow", bus.dump_overflow_o, 0);
    chk("rst_overrun",  bus.dump_overrun_o,  0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_b) begin
      chk("valid",   bus.dump_valid_o,   vis_full);
      chk("overrun", bus.dump_overrun_o, vis_ovr);
      chk("dbg",     dbg_hold_full,      vis_full);
      if (bus.dump_valid_o && bus.dump_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dump", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("value",    $signed(bus.dump_value_o), $signed(e[W-1:0]));
          chk("overflow", bus.dump_overflow_o,       e[W]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int len_r;
    do_reset();

    // basic sum, length 4
    step(1, 0, 225, 4, 1, 0); step(1, 0, 225, 4, 1, 0);
    step(1, 1, 10, 4, 1, 0);  step(1, 0, 3, 4, 1, 0);
    idle(3, 1);

    // length 0 behaves as 1, back-to-back
    step(1, 0, 5, 0, 1, 0); step(1, 1, 7, 0, 1, 0); step(1, 0, 1, 0, 1, 0);
    idle(3, 1);

    // overrun, then simultaneous completion + accept
    step(1, 0, 1, 1, 0, 0); step(1, 0, 2, 1, 0, 0);
    idle(2, 0); idle(2, 1);
    step(1, 0, 1, 1, 0, 0); step(1, 0, 2, 1, 1, 0);
    idle(3, 1);

    // saturation / wrap, then a short negative period
    for (int i = 0; i < 3; i++) step(1, 0, 225, 3, 1, 0);
    step(1, 1, 4, 1, 1, 0);
    idle(3, 1);

    // clear mid-period
    for (int i = 0; i < 3; i++) step(1, 0, 100, 8, 1, 0);
    step(1, 0, 100, 8, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 8, 1, 0);
    idle(3, 1);

    // reset mid-period
    for (int i = 0; i < 3; i++) step(1, 0, 100, 8, 1, 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 1, 8, 1, 0);
    idle(3, 1);

    // length change takes effect next period
    step(1, 0, 11, 2, 1, 0);
    step(1, 0, 12, 3, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 20 + i, 3, 1, 0);
    idle(3, 1);

    // random traffic
    len_r = 3;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) len_r = $urandom_range(0, 6);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1),
           $urandom_range(0, 225), len_r,
           $urandom_range(0, 2) != 0, $urandom_range(0, 79) == 0);
    end

    idle(4, 1);
    @(posedge clk); #1;
    chk("drain_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
